// File: rtl/edram_ctrl_if.sv
// Client request/response and eDRAM macro port bundle for edram_ctrl.
// master: the environment (client plus macro read-data return); slave: the controller.
// Widths follow the macro geometry so both sides agree on row and data sizes.
interface edram_ctrl_if #(
    parameter int DATA_W    = 343,
    parameter int ROWS_LOG2 = 9
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ROWS_LOG2-1:0] req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 port_en;
    logic                 port_ref_plus2;
    logic [ROWS_LOG2-1:0] port_read_addr;
    logic [ROWS_LOG2-1:0] port_write_addr;
    logic                 port_wen_plus3;
    logic                 port_data;
    logic [DATA_W-1:0]    port_write_data;
    logic [DATA_W-1:0]    port_read_data;
    logic                 ref_overflow;
    logic [ROWS_LOG2-1:0] ref_row;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, port_read_data,
        input  req_ready, rsp_valid, rsp_data, port_en, port_ref_plus2,
        input  port_read_addr, port_write_addr, port_wen_plus3, port_data,
        input  port_write_data, ref_overflow, ref_row
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, port_read_data,
        output req_ready, rsp_valid, rsp_data, port_en, port_ref_plus2,
        output port_read_addr, port_write_addr, port_wen_plus3, port_data,
        output port_write_data, ref_overflow, ref_row
    );
endinterface

// File: rtl/edram_ctrl.sv
// eDRAM requester: 4-clk read/ECC/writeback slots shared by client ops and periodic row refresh.
// Latency: read data returned 5 clk after acceptance (rsp_valid pulse); writes return nothing.
// Backpressure: req_ready only at slot start (phase 0) and only while owed refreshes < REF_URGENT.
module edram_ctrl #(
    parameter int DATA_W       = 343,
    parameter int ROWS_LOG2    = 9,
    parameter int REF_INTERVAL = 64,
    parameter int REF_URGENT   = 4,
    parameter int REF_MAX_OWED = 8
) (
    input  logic         clk,
    input  logic         rst,
    edram_ctrl_if.slave  bus
);

    // Owed counter is wide enough to hold both the saturation limit and the urgency threshold.
    localparam int OWED_W  = $clog2(REF_MAX_OWED + REF_URGENT + 1);
    localparam int TIMER_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [OWED_W-1:0]  URGENT_C   = OWED_W'(REF_URGENT);
    localparam logic [OWED_W-1:0]  MAX_C      = OWED_W'(REF_MAX_OWED);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REF_INTERVAL - 1);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_REF   = 2'd3
    } op_e;

    logic [1:0]           phase_q, phase_d;
    logic                 req_ready_q, req_ready_d;
    logic [OWED_W-1:0]    owed_q, owed_d;
    logic                 ovf_set;
    logic [TIMER_W-1:0]   timer_q;
    logic                 ref_overflow_q;

    op_e                  op_q;
    logic [ROWS_LOG2-1:0] addr_q;
    logic [ROWS_LOG2-1:0] ref_row_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 port_data_q;
    logic                 port_wen_q;
    logic                 rd_pend_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_data_q;

    logic                 slot_start;
    logic                 accept;
    logic                 do_ref;
    logic                 credit;
    logic [ROWS_LOG2-1:0] slot_addr;

    // Slot decision at phase 0: accepted client op beats refresh, refresh beats idle.
    always_comb begin
        slot_start = !rst && (phase_q == 2'd0);
        accept     = slot_start && bus.req_valid && req_ready_q;
        do_ref     = slot_start && !accept && (owed_q != '0);
        credit     = (timer_q == TIMER_LAST);
        slot_addr  = addr_q;
        if (accept) begin
            slot_addr = bus.req_addr;
        end else if (do_ref) begin
            slot_addr = ref_row_q;
        end
    end

    // Owed-refresh bookkeeping; a simultaneous credit and refresh cancel out, and a credit
    // arriving at saturation is dropped and flagged.
    always_comb begin
        owed_d  = owed_q;
        ovf_set = 1'b0;
        phase_d = phase_q + 2'd1;
        case ({credit, do_ref})
            2'b10: begin
                if (owed_q == MAX_C) begin
                    ovf_set = 1'b1;
                end else begin
                    owed_d = owed_q + 1'b1;
                end
            end
            2'b01:   owed_d = owed_q - 1'b1;
            default: owed_d = owed_q;
        endcase
        req_ready_d = (phase_d == 2'd0) && (owed_d < URGENT_C);
    end

    // Phase counter, refresh timer, owed count and the registered ready decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= 2'd0;
            req_ready_q    <= 1'b0;
            owed_q         <= '0;
            timer_q        <= '0;
            ref_overflow_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            req_ready_q <= req_ready_d;
            owed_q      <= owed_d;
            timer_q     <= credit ? '0 : timer_q + 1'b1;
            if (ovf_set) begin
                ref_overflow_q <= 1'b1;
            end
        end
    end

    // Slot sequencer: latches the op at phase 0, then fires data inject (phase 2),
    // writeback (phase 3) and the read return that straddles into the next slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            port_data_q <= 1'b0;
            port_wen_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ref_row_q   <= '0;
        end else begin
            port_data_q <= (phase_q == 2'd1) && (op_q == OP_WRITE);
            port_wen_q  <= (phase_q == 2'd2) && (op_q != OP_IDLE);
            rsp_valid_q <= 1'b0;
            case (phase_q)
                2'd0: begin
                    // Corrected data of the previous slot's read is on the macro bus now.
                    if (rd_pend_q) begin
                        rsp_data_q  <= bus.port_read_data;
                        rsp_valid_q <= 1'b1;
                        rd_pend_q   <= 1'b0;
                    end
                    if (accept) begin
                        op_q   <= bus.req_write ? OP_WRITE : OP_READ;
                        addr_q <= bus.req_addr;
                        if (bus.req_write) begin
                            wdata_q <= bus.req_wdata;
                        end
                    end else if (do_ref) begin
                        op_q   <= OP_REF;
                        addr_q <= ref_row_q;
                    end else begin
                        op_q <= OP_IDLE;
                    end
                end
                2'd3: begin
                    rd_pend_q <= (op_q == OP_READ);
                    if (op_q == OP_REF) begin
                        ref_row_q <= ref_row_q + 1'b1;
                    end
                    op_q <= OP_IDLE;
                end
                default: begin
                    op_q <= op_q;
                end
            endcase
        end
    end

    // Phase-0 strobes are decoded directly so the macro sees them in the accept cycle;
    // the address mux falls back to the latched row for the rest of the slot.
    assign bus.req_ready       = req_ready_q;
    assign bus.port_en         = accept;
    assign bus.port_ref_plus2  = do_ref;
    assign bus.port_read_addr  = slot_addr;
    assign bus.port_write_addr = slot_addr;
    assign bus.port_wen_plus3  = port_wen_q;
    assign bus.port_data       = port_data_q;
    assign bus.port_write_data = wdata_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.ref_overflow    = ref_overflow_q;
    assign bus.ref_row         = ref_row_q;

endmodule
